regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file, the next generation of the processor's 32×32 two-read/one-write GPR file. It is generalised in width, depth and read-port count, and adds the following:
- an optional hardwired-zero register 0;
- write-to-read bypass;
- selectable combinational or registered read latency;
- a sequential clear sweep that zeroes the array after reset or on request.

It sits between decode, which supplies read addresses, and writeback, which supplies the write port.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_mp_if.sv | 27 ++
 rtl/regfile_read_port.sv | 53 +++++
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port general-purpose register file.
// Holds the sweep state encoding, default geometry and a constant-foldable log2 helper.
package regfile_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  localparam int unsigned DEF_WIDTH = 32'd32;
  localparam int unsigned DEF_DEPTH = 32'd32;
  localparam int unsigned DEF_NREAD = 32'd2;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 32'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side bundle of the register file: one write port, NREAD packed read ports
// and the ready indication.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = clog2(DEF_DEPTH),
  parameter int unsigned NREAD = DEF_NREAD
);
  logic                   rw;
  logic [AW-1:0]          d_addr;
  logic [WIDTH-1:0]       data;
  logic                   clear;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic                   ready;

  modport master (
    output rw, d_addr, data, clear, rd_addr,
    input  rd_data, ready
  );

  modport slave (
    input  rw, d_addr, data, clear, rd_addr,
    output rd_data, ready
  );
endinterface

// File: rtl/regfile_read_port.sv
// One read port: address mux, write bypass, zero forcing and an optional output register.
// The register clears when the array leaves RUN so a sweep always presents zeros.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned ZERO_REG = 32'd1,
  parameter int unsigned READ_LAT = 32'd0,
  parameter int unsigned AW       = clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
  input  logic [AW-1:0]                rd_addr,
  input  logic                         ready,
  input  logic                         byp_en,
  input  logic [AW-1:0]                byp_addr,
  input  logic [WIDTH-1:0]             byp_data,
  input  logic                         flush,
  output logic [WIDTH-1:0]             rd_data
);

  logic             zero_hit_s;
  logic [WIDTH-1:0] val_s;
  logic [WIDTH-1:0] q_r;

  assign zero_hit_s = (ZERO_REG != 32'd0) && (rd_addr == {AW{1'b0}});

  // Read value selection: zero forcing beats bypass, bypass beats the array
  always_comb begin
    val_s = {WIDTH{1'b0}};
    if (!ready || zero_hit_s) begin
      val_s = {WIDTH{1'b0}};
    end else if (byp_en && (byp_addr == rd_addr)) begin
      val_s = byp_data;
    end else begin
      val_s = mem[rd_addr];
    end
  end

  // Output register used when READ_LAT is 1
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_r <= {WIDTH{1'b0}};
    end else begin
      q_r <= val_s;
    end
  end

  assign rd_data = (READ_LAT == 32'd1) ? q_r : val_s;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with a DEPTH-edge clear sweep after reset or on request.
// The top owns the array, the write path and the INIT/RUN sweep controller.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NREAD    = DEF_NREAD,
  parameter int unsigned ZERO_REG = 32'd1,
  parameter int unsigned READ_LAT = 32'd0
) (
  input logic        clk,
  input logic        rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned AW = clog2(DEPTH);

  rf_state_e                   state_r;
  rf_state_e                   state_nxt_s;
  logic [AW-1:0]               ptr_r;
  logic [AW-1:0]               ptr_nxt_s;
  logic                        ready_r;
  logic [DEPTH-1:0][WIDTH-1:0] mem_r;
  logic                        last_s;
  logic                        writable_s;
  logic                        sweep_wr_s;
  logic                        run_wr_s;
  logic                        byp_en_s;
  logic                        flush_s;

  assign last_s     = (ptr_r == AW'(DEPTH - 32'd1));
  assign writable_s = (ZERO_REG == 32'd0) || (bus.d_addr != {AW{1'b0}});
  assign sweep_wr_s = !rst && (state_r == INIT);
  assign run_wr_s   = !rst && (state_r == RUN) && !bus.clear && bus.rw && writable_s;
  assign byp_en_s   = bus.rw && ready_r && writable_s;
  assign flush_s    = ready_r && bus.clear;
  assign bus.ready  = ready_r;

  // Sweep controller next state; clear is only honoured from RUN
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      INIT: begin
        ptr_nxt_s = ptr_r + AW'(1'b1);
        if (last_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = INIT;
        end
      end
      RUN: begin
        if (bus.clear) begin
          state_nxt_s = INIT;
          ptr_nxt_s   = {AW{1'b0}};
        end else begin
          state_nxt_s = RUN;
          ptr_nxt_s   = ptr_r;
        end
      end
      default: begin
        state_nxt_s = INIT;
        ptr_nxt_s   = {AW{1'b0}};
      end
    endcase
  end

  // Sweep controller state, pointer and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= INIT;
      ptr_r   <= {AW{1'b0}};
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      ready_r <= (state_nxt_s == RUN);
    end
  end

  // Array update: zeroing during the sweep, port writes while running
  always_ff @(posedge clk) begin
    if (sweep_wr_s) begin
      mem_r[ptr_r] <= {WIDTH{1'b0}};
    end else if (run_wr_s) begin
      mem_r[bus.d_addr] <= bus.data;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .READ_LAT (READ_LAT),
      .AW       (AW)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .mem      (mem_r),
      .rd_addr  (bus.rd_addr[k*AW +: AW]),
      .ready    (ready_r),
      .byp_en   (byp_en_s),
      .byp_addr (bus.d_addr),
      .byp_data (bus.data),
      .flush    (flush_s),
      .rd_data  (bus.rd_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances (combinational, registered, no zero register)
// share one stimulus; expected values come from a hand-built vector table.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rw;
  logic        clear;
  logic [4:0]  d_addr;
  logic [31:0] data;
  logic [4:0]  ra0;
  logic [4:0]  ra1;

  int passed = 0;
  int total  = 0;

  regfile_mp_if #(.WIDTH(32), .AW(5), .NREAD(2)) if_a ();
  regfile_mp_if #(.WIDTH(32), .AW(5), .NREAD(2)) if_b ();
  regfile_mp_if #(.WIDTH(32), .AW(5), .NREAD(2)) if_c ();

  assign if_a.rw = rw;  assign if_a.clear = clear;  assign if_a.d_addr = d_addr;
  assign if_a.data = data;  assign if_a.rd_addr = {ra1, ra0};
  assign if_b.rw = rw;  assign if_b.clear = clear;  assign if_b.d_addr = d_addr;
  assign if_b.data = data;  assign if_b.rd_addr = {ra1, ra0};
  assign if_c.rw = rw;  assign if_c.clear = clear;  assign if_c.d_addr = d_addr;
  assign if_c.data = data;  assign if_c.rd_addr = {ra1, ra0};

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .READ_LAT(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .READ_LAT(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(0), .READ_LAT(0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;   // ZERO_REG=1 port 0
    logic [31:0] e1;   // ZERO_REG=1 port 1
    logic [31:0] ec0;  // ZERO_REG=0 port 0
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] ec0);
    vec_t v;
    v.rw = w; v.wa = wa; v.wd = wd; v.ra0 = a0; v.ra1 = a1;
    v.e0 = e0; v.e1 = e1; v.ec0 = ec0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until dut_a reports ready, bounded so a stuck sweep cannot hang the run.
  task automatic count_sweep(input string name);
    int n;
    n = 0;
    while (n < 100 && if_a.ready !== 1'b1) begin
      step();
      n++;
    end
    check({name, "_edges"}, 32'(n), 32'd32);
    check({name, "_ready_b"}, 32'(if_b.ready), 32'd1);
    check({name, "_ready_c"}, 32'(if_c.ready), 32'd1);
  endtask

  initial begin
    logic [31:0] e1v;
    rst = 1'b1; rw = 1'b0; clear = 1'b0; d_addr = 5'd0; data = 32'd0;
    ra0 = 5'd0; ra1 = 5'd0;

    // Vector table: fill with bypass, reverse read, zero register, bypass pattern
    for (int i = 0; i < 32; i++) begin
      e1v = ((31 - i) < i) ? 32'(31 - i) : 32'd0;
      vecs.push_back(mk(1'b1, 5'(i), 32'(i), 5'(i), 5'(31 - i), 32'(i), e1v, 32'(i)));
    end
    for (int i = 0; i < 32; i++) begin
      vecs.push_back(mk(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 32'(i), 32'(31 - i), 32'(i)));
    end
    vecs.push_back(mk(1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0, 32'd0, 32'd0, 32'h0000_1234));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h0000_1234));
    vecs.push_back(mk(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 5'd5, 5'd6, 32'hDEAD_BEEF, 32'd6, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b1, 5'd6, 32'hA5A5_0F0F, 5'd7, 5'd6, 32'd7, 32'hA5A5_0F0F, 32'd7));

    // Reset for two edges, then the sweep
    step();
    check("rst_ready_a", 32'(if_a.ready), 32'd0);
    check("rst_ready_b", 32'(if_b.ready), 32'd0);
    check("rst_b_rd0", if_b.rd_data[31:0], 32'd0);
    check("rst_b_rd1", if_b.rd_data[63:32], 32'd0);
    check("rst_a_rd0", if_a.rd_data[31:0], 32'd0);
    step();
    rst = 1'b0;
    count_sweep("reset_sweep");

    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i);
      #2;
      check($sformatf("zero_a%0d", i), if_a.rd_data[31:0] | if_a.rd_data[63:32], 32'd0);
      check($sformatf("zero_c%0d", i), if_c.rd_data[31:0] | if_c.rd_data[63:32], 32'd0);
      step();
    end

    for (int i = 0; i < vecs.size(); i++) begin
      rw = vecs[i].rw; d_addr = vecs[i].wa; data = vecs[i].wd;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      #2;
      check($sformatf("v%0d_a0", i), if_a.rd_data[31:0], vecs[i].e0);
      check($sformatf("v%0d_a1", i), if_a.rd_data[63:32], vecs[i].e1);
      check($sformatf("v%0d_c0", i), if_c.rd_data[31:0], vecs[i].ec0);
      step();
      check($sformatf("v%0d_b0", i), if_b.rd_data[31:0], vecs[i].e0);
      check($sformatf("v%0d_b1", i), if_b.rd_data[63:32], vecs[i].e1);
    end
    rw = 1'b0;

    // Clear colliding with a write to address 7 (holding 7 from the fill)
    clear = 1'b1; rw = 1'b1; d_addr = 5'd7; data = 32'd9; ra0 = 5'd7; ra1 = 5'd7;
    step();
    clear = 1'b0; rw = 1'b0;
    check("clr_ready_a", 32'(if_a.ready), 32'd0);
    check("clr_b_rd0", if_b.rd_data[31:0], 32'd0);
    count_sweep("clear_sweep");
    #2;
    check("clr_mem7_a", if_a.rd_data[31:0], 32'd0);
    check("clr_mem7_c", if_c.rd_data[31:0], 32'd0);
    step();
    check("clr_mem7_b", if_b.rd_data[31:0], 32'd0);

    // Reset again, then hit the sweep with reset at its tenth edge
    rst = 1'b1;
    step();
    rst = 1'b0;
    rw = 1'b1; d_addr = 5'd3; data = 32'h0000_0055; ra0 = 5'd3;
    #2;
    check("init_nobyp_a", if_a.rd_data[31:0], 32'd0);
    check("init_nobyp_c", if_c.rd_data[31:0], 32'd0);
    for (int k = 1; k < 10; k++) begin
      step();
      rw = 1'b0;
    end
    check("mid_ready_a", 32'(if_a.ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_sweep("mid_sweep");
    ra0 = 5'd3; ra1 = 5'd3;
    #2;
    check("mid_mem3_a", if_a.rd_data[31:0], 32'd0);
    check("mid_mem3_c", if_c.rd_data[31:0], 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
